// File: rtl/mem_sram_ctrl.sv
// Clocked data memory with a CPU read/write port, an external load port and a
// zero-fill sweep after reset. Optional per-word even parity under MEM_PARITY_EN.
module mem_sram_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              ewr,
   input  logic [ADDR_W-1:0] ead,
   input  logic [DATA_W-1:0] edat,
   input  logic              mrd,
   input  logic              mwr,
   input  logic [ADDR_W-1:0] mad,
   input  logic [DATA_W-1:0] mwdat,
   output logic [DATA_W-1:0] mrdat,
   output logic              mrvalid,
   output logic              busy,
   output logic              perr
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned PTR_W = ADDR_W + 1;
`ifdef MEM_PARITY_EN
   localparam int unsigned MEM_W = DATA_W + 1;
`else
   localparam int unsigned MEM_W = DATA_W;
`endif

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_RUN   = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [PTR_W-1:0]    r_clr_ptr;
   logic [PTR_W-1:0]    w_clr_ptr_nxt;
   logic                r_busy;
   logic [DATA_W-1:0]   r_mrdat;
   logic                r_mrvalid;
   logic                w_we;
   logic                w_rd;
   logic [ADDR_W-1:0]   w_waddr;
   logic [DATA_W-1:0]   w_wdata;
   logic [MEM_W-1:0]    w_wword;
   logic [MEM_W-1:0]    w_rword;
   logic [MEM_W-1:0]    r_mem [DEPTH];

   // State, sweep pointer and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_CLEAR;
         r_clr_ptr <= '0;
         r_busy    <= 1'b1;
         r_mrdat   <= '0;
         r_mrvalid <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
         r_busy    <= (w_state_nxt == S_CLEAR);
         r_mrvalid <= w_rd;
         if (w_rd) begin
            r_mrdat <= w_rword[DATA_W-1:0];
         end
      end
   end

   // Next state and port arbitration: load > CPU write > CPU read
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_we          = 1'b0;
      w_rd          = 1'b0;
      w_waddr       = mad;
      w_wdata       = mwdat;
      case (r_state)
         S_CLEAR: begin
            w_we          = 1'b1;
            w_waddr       = r_clr_ptr[ADDR_W-1:0];
            w_wdata       = '0;
            w_clr_ptr_nxt = PTR_W'(r_clr_ptr + PTR_W'(1));
            if (r_clr_ptr == PTR_W'(DEPTH - 1)) begin
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (load) begin
               w_we    = ewr;
               w_waddr = ead;
               w_wdata = edat;
            end else if (mwr) begin
               w_we    = 1'b1;
               w_waddr = mad;
               w_wdata = mwdat;
            end else if (mrd) begin
               w_rd = 1'b1;
            end
         end
         default: w_state_nxt = S_CLEAR;
      endcase
   end

`ifdef MEM_PARITY_EN
   logic r_perr;

   assign w_wword = {^w_wdata, w_wdata};

   // Sticky flag: any stored word with odd overall parity on a CPU read
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perr <= 1'b0;
      end else if (w_rd && (^w_rword)) begin
         r_perr <= 1'b1;
      end
   end

   assign perr = r_perr;
`else
   assign w_wword = w_wdata;
   assign perr    = 1'b0;
`endif

   // Storage array; contents are defined only after the sweep
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wword;
      end
   end

   assign w_rword = r_mem[mad];
   assign mrdat   = r_mrdat;
   assign mrvalid = r_mrvalid;
   assign busy    = r_busy;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl: reset sweep, vector table for the RUN
// priorities, mid-sweep reset and (with MEM_PARITY_EN) the sticky parity flag.
module tb_mem_sram_ctrl;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DEPTH  = 2**ADDR_W;

   logic              clk;
   logic              rst;
   logic              load;
   logic              ewr;
   logic [ADDR_W-1:0] ead;
   logic [DATA_W-1:0] edat;
   logic              mrd;
   logic              mwr;
   logic [ADDR_W-1:0] mad;
   logic [DATA_W-1:0] mwdat;
   logic [DATA_W-1:0] mrdat;
   logic              mrvalid;
   logic              busy;
   logic              perr;

   int n_checks;
   int n_errors;

   typedef struct {
      logic              load;
      logic              ewr;
      logic [ADDR_W-1:0] ead;
      logic [DATA_W-1:0] edat;
      logic              mrd;
      logic              mwr;
      logic [ADDR_W-1:0] mad;
      logic [DATA_W-1:0] mwdat;
      logic [DATA_W-1:0] exp_mrdat;
      logic              exp_mrvalid;
   } vec_t;

   vec_t vecs [16];

   mem_sram_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk     (clk),
      .rst     (rst),
      .load    (load),
      .ewr     (ewr),
      .ead     (ead),
      .edat    (edat),
      .mrd     (mrd),
      .mwr     (mwr),
      .mad     (mad),
      .mwdat   (mwdat),
      .mrdat   (mrdat),
      .mrvalid (mrvalid),
      .busy    (busy),
      .perr    (perr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      load = 1'b0; ewr = 1'b0; ead = '0; edat = '0;
      mrd = 1'b0; mwr = 1'b0; mad = '0; mwdat = '0;
   endtask

   // One cycle: drive at negedge, sample at the following negedge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sweep cycles with CPU requests that must all be ignored
   task automatic sweep_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         check("busy_sweep", 32'(busy), 32'd1);
         check("mrvalid_sweep", 32'(mrvalid), 32'd0);
         load  = 1'b0;
         mad   = ADDR_W'(2);
         mwdat = 8'h99;
         mwr   = (i % 2 == 0);
         mrd   = (i % 2 == 1);
         step();
      end
      idle_inputs();
   endtask

   task automatic cpu_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string name);
      idle_inputs();
      mrd = 1'b1;
      mad = a;
      step();
      idle_inputs();
      check({name, "_mrdat"}, 32'(mrdat), 32'(exp));
      check({name, "_mrvalid"}, 32'(mrvalid), 32'd1);
   endtask

   task automatic check_reset_vals(input string name);
      check({name, "_busy"}, 32'(busy), 32'd1);
      check({name, "_mrdat"}, 32'(mrdat), 32'd0);
      check({name, "_mrvalid"}, 32'(mrvalid), 32'd0);
      check({name, "_perr"}, 32'(perr), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      idle_inputs();

      //                 load ewr ead    edat   mrd  mwr  mad    mwdat  exp_d  exp_v
      vecs[0]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd31, 8'h00, 8'h00, 1'b1};
      vecs[1]  = '{1'b1, 1'b1, 5'd3,  8'hA5, 1'b0, 1'b1, 5'd3,  8'hFF, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd3,  8'h00, 8'hA5, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 5'd31, 8'h3C, 8'hA5, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd31, 8'h00, 8'h3C, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd0,  8'h00, 8'h00, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b1, 5'd7,  8'h55, 8'h00, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd7,  8'h00, 8'h55, 1'b1};
      vecs[8]  = '{1'b1, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd3,  8'h00, 8'h55, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 5'd4,  8'h77, 1'b0, 1'b0, 5'd0,  8'h00, 8'h55, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd4,  8'h00, 8'h00, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b1, 5'd0,  8'hAA, 8'h00, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd0,  8'h00, 8'hAA, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b0, 1'b0, 5'd0,  8'h00, 8'hAA, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 5'd0,  8'h11, 1'b0, 1'b0, 5'd0,  8'h00, 8'hAA, 1'b0};
      vecs[15] = '{1'b0, 1'b0, 5'd0,  8'h00, 1'b1, 1'b0, 5'd0,  8'h00, 8'h11, 1'b1};

      // Power-on reset and full sweep
      rst = 1'b1;
      step();
      step();
      check_reset_vals("por");
      rst = 1'b0;
      sweep_cycles(DEPTH);
      check("busy_after_sweep", 32'(busy), 32'd0);

      // RUN-mode vector table
      for (int i = 0; i < 16; i++) begin
         load  = vecs[i].load;
         ewr   = vecs[i].ewr;
         ead   = vecs[i].ead;
         edat  = vecs[i].edat;
         mrd   = vecs[i].mrd;
         mwr   = vecs[i].mwr;
         mad   = vecs[i].mad;
         mwdat = vecs[i].mwdat;
         step();
         check($sformatf("vec%0d_mrdat", i), 32'(mrdat), 32'(vecs[i].exp_mrdat));
         check($sformatf("vec%0d_mrvalid", i), 32'(mrvalid), 32'(vecs[i].exp_mrvalid));
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
         check($sformatf("vec%0d_perr", i), 32'(perr), 32'd0);
      end
      idle_inputs();

      // Asynchronous reset from RUN: outputs drop without a clock edge
      #1 rst = 1'b1;
      #1 check_reset_vals("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // Reset again 10 cycles into the sweep, then a full sweep follows
      sweep_cycles(10);
      rst = 1'b1;
      #1 check_reset_vals("mid_sweep_rst");
      @(negedge clk);
      rst = 1'b0;
      sweep_cycles(DEPTH);
      check("busy_after_resweep", 32'(busy), 32'd0);
      cpu_read(ADDR_W'(3), 8'h00, "resweep_a3");
      cpu_read(ADDR_W'(2), 8'h00, "resweep_a2");
      cpu_read(ADDR_W'(0), 8'h00, "resweep_a0");

`ifdef MEM_PARITY_EN
      // Corrupt one stored bit and confirm the sticky parity flag
      idle_inputs();
      mwr = 1'b1; mad = ADDR_W'(5); mwdat = 8'h0F;
      step();
      idle_inputs();
      dut.r_mem[5][0] = ~dut.r_mem[5][0];
      check("perr_before_read", 32'(perr), 32'd0);
      cpu_read(ADDR_W'(5), 8'h0E, "par_bad");
      check("perr_set", 32'(perr), 32'd1);
      cpu_read(ADDR_W'(4), 8'h00, "par_clean");
      check("perr_sticky", 32'(perr), 32'd1);
      step();
      check("perr_sticky_idle", 32'(perr), 32'd1);
      rst = 1'b1;
      #1 check("perr_cleared", 32'(perr), 32'd0);
      @(negedge clk);
      rst = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
